dmem_responder: RTL

Memory-side responder for the CPU data port. It accepts one load or store request at a time over a valid/ready handshake and applies byte/half/word lane selection. Sub-word stores are performed as read-modify-write on a single-port word RAM. Loads return sign- or zero-extended data. The block sits between the CPU memory stage and the data memory array that holds the testbench-visible `data_mem` contents.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_sram_1p.sv | 21 ++
 rtl/dmem_responder.sv | 113 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, FSM states and lane helpers for the data-memory responder
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

    function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        return (size == SIZE_B ? 32'h0000_00FF : size == SIZE_H ? 32'h0000_FFFF : 32'hFFFF_FFFF) << {off, 3'b000};
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return size == 2'b11 || (size == SIZE_W && off != 2'd0) || (size == SIZE_H && off == 2'd3);
    endfunction

endpackage

// File: rtl/dmem_sram_1p.sv
// dmem_sram_1p: single-port word RAM with synchronous read and full-word write
module dmem_sram_1p #(
    parameter int DEPTH_WORDS = 16384,
    parameter int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   q
);

    logic [31:0] data_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en && we) data_mem[addr] <= wdata;
        if (en && !we) q <= data_mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time load/store responder with byte/half lane select and RMW sub-word stores
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 16384,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t state, state_nx;
    logic [1:0] cap_off, cap_size;
    logic cap_uns, cap_we;
    logic [31:0] cap_wdata;
    logic [AW-1:0] cap_idx;
    logic accept, mis_in, ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_wdata, ram_q, lane, load_val, mask, merged;
    logic unused_addr;

    assign unused_addr = ^req_addr[ADDR_WIDTH-1:AW+2];
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign accept = req_valid && req_ready;
    assign mis_in = is_misaligned(req_size, req_addr[1:0]);

    assign lane = ram_q >> {cap_off, 3'b000};
    assign load_val = cap_size == SIZE_B ? {{24{~cap_uns & lane[7]}}, lane[7:0]}
                    : cap_size == SIZE_H ? {{16{~cap_uns & lane[15]}}, lane[15:0]} : lane;
    assign mask = lane_mask(cap_size, cap_off);
    assign merged = (ram_q & ~mask) | ((cap_wdata << {cap_off, 3'b000}) & mask);

    // IDLE drives the RAM straight from the request; RD only ever writes back the merged word
    always_comb begin
        state_nx = state;
        ram_en = 1'b0;
        ram_we = 1'b0;
        ram_addr = cap_idx;
        ram_wdata = merged;
        if (state == IDLE) begin
            ram_addr = req_addr[2 +: AW];
            ram_wdata = req_wdata;
            ram_en = accept && !mis_in;
            ram_we = req_we && req_size == SIZE_W;
            if (accept) state_nx = (mis_in || ram_we) ? RESP : RD;
        end else if (state == RD) begin
            ram_en = cap_we;
            ram_we = cap_we;
            state_nx = RESP;
        end else if (rsp_ready) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_off <= 2'd0;
            cap_size <= 2'd0;
            cap_uns <= 1'b0;
            cap_we <= 1'b0;
            cap_wdata <= 32'd0;
            cap_idx <= '0;
        end else if (accept) begin
            cap_off <= req_addr[1:0];
            cap_size <= req_size;
            cap_uns <= req_unsigned;
            cap_we <= req_we;
            cap_wdata <= req_wdata;
            cap_idx <= req_addr[2 +: AW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= 32'd0;
            rsp_misaligned <= 1'b0;
        end else if (accept) begin
            rsp_rdata <= 32'd0;
            rsp_misaligned <= mis_in;
        end else if (state == RD) begin
            rsp_rdata <= cap_we ? 32'd0 : load_val;
        end
    end

    dmem_sram_1p #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .q    (ram_q)
    );

endmodule
